mmc_chan_cmd_sched: RTL

- Per-channel DRAM command scheduler in the main memory controller, one instance per DRAM channel.
- Arbitrates among NUM_REQ requester streams (read/write request ports) for the single command slot per `clk` cycle.
- Enforces per-bank busy time and write-to-read turnaround before issuing.
- Drives the per-channel mmc__dfi__cs/cmd1/cmd0/bank/addr inputs of the DFI SDR->DDR block.

---
 rtl/mmc_chan_cmd_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mmc_chan_cmd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmc_chan_cmd_sched : per-channel round-robin DRAM command scheduler (rev 1.0)
// ---------------------------------------------------------------------------
module mmc_chan_cmd_sched #(
    parameter int NUM_REQ   = 2,
    parameter int NUM_BANKS = 32,
    parameter int BANK_W    = 5,
    parameter int ADDR_W    = 13,
    parameter int T_BANK    = 4,
    parameter int T_WTR     = 2
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic                      dfi__mmc__init_done,
    input  logic [NUM_REQ-1:0]        req__sched__valid,
    input  logic [NUM_REQ-1:0]        req__sched__wr,
    input  logic [NUM_REQ*BANK_W-1:0] req__sched__bank,
    input  logic [NUM_REQ*ADDR_W-1:0] req__sched__addr,
    output logic [NUM_REQ-1:0]        sched__req__ready,
    output logic                      mmc__dfi__cs,
    output logic                      mmc__dfi__cmd1,
    output logic                      mmc__dfi__cmd0,
    output logic [BANK_W-1:0]         mmc__dfi__bank,
    output logic [ADDR_W-1:0]         mmc__dfi__addr,
    output logic                      sched__busy
);
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [0:0] {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [3:0]          bank_timer_q [NUM_BANKS];
    logic [3:0]          bank_timer_d [NUM_BANKS];
    logic [2:0]          wtr_q, wtr_d;
    logic                cs_q, cs_d, cmd1_q, cmd1_d, cmd0_q, cmd0_d, busy_q, busy_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [NUM_REQ-1:0]  elig;
    logic                gnt_vld;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_wr;
    logic [BANK_W-1:0]   gnt_bank;
    logic [ADDR_W-1:0]   gnt_addr;

    // A timer at 1 expires on this edge, so the bank (or read path) may be
    // granted now; this makes a grant-to-grant spacing of exactly T cycles.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req__sched__valid[i]
                   && (bank_timer_q[req__sched__bank[i*BANK_W +: BANK_W]] <= 4'd1)
                   && (req__sched__wr[i] || (wtr_q <= 3'd1));
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_vld && (state_q == RUN) && dfi__mmc__init_done
                && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign gnt_wr            = req__sched__wr[gnt_idx];
    assign gnt_bank          = req__sched__bank[gnt_idx*BANK_W +: BANK_W];
    assign gnt_addr          = req__sched__addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sched__req__ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_INIT: if (dfi__mmc__init_done)  state_d = RUN;
            RUN:       if (!dfi__mmc__init_done) state_d = WAIT_INIT;
        endcase

        ptr_d  = gnt_vld ? PTR_W'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
        busy_d = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_timer_d[b] = (bank_timer_q[b] != 4'd0) ? bank_timer_q[b] - 4'd1 : 4'd0;
            if (gnt_vld && (gnt_bank == BANK_W'(b))) bank_timer_d[b] = 4'(T_BANK);
            busy_d = busy_d | (bank_timer_d[b] != 4'd0);
        end

        wtr_d = (wtr_q != 3'd0) ? wtr_q - 3'd1 : 3'd0;
        if (gnt_vld && gnt_wr) wtr_d = 3'(T_WTR);
        busy_d = busy_d | (wtr_d != 3'd0);

        cs_d   = gnt_vld;
        cmd1_d = gnt_vld & gnt_wr;
        cmd0_d = gnt_vld & ~gnt_wr;
        bank_d = gnt_vld ? gnt_bank : bank_q;
        addr_d = gnt_vld ? gnt_addr : addr_q;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= WAIT_INIT;
            ptr_q   <= '0;
            for (int b = 0; b < NUM_BANKS; b++) bank_timer_q[b] <= 4'd0;
            wtr_q   <= 3'd0;
            cs_q    <= 1'b0;
            cmd1_q  <= 1'b0;
            cmd0_q  <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            bank_timer_q <= bank_timer_d;
            wtr_q        <= wtr_d;
            cs_q         <= cs_d;
            cmd1_q       <= cmd1_d;
            cmd0_q       <= cmd0_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
        end
    end

    assign mmc__dfi__cs   = cs_q;
    assign mmc__dfi__cmd1 = cmd1_q;
    assign mmc__dfi__cmd0 = cmd0_q;
    assign mmc__dfi__bank = bank_q;
    assign mmc__dfi__addr = addr_q;
    assign sched__busy    = busy_q;

endmodule
`default_nettype wire
